// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller.
// Holds the FSM state encoding, the op_code encodings and the default
// latency/timeout values used as parameter defaults by muldiv_ctrl.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OpMult  = 2'd0,
    OpMultu = 2'd1,
    OpDiv   = 2'd2,
    OpDivu  = 2'd3
  } op_t;

  localparam int unsigned MulLatDefault     = 6;
  localparam int unsigned DivTimeoutDefault = 40;

endpackage

// File: rtl/muldiv_cnt.sv
// Cycle counter shared by the MUL and DIV states.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset (zeroes the count)
//   i_clr  - synchronous clear (takes priority over i_en)
//   i_en   - increment enable
//   i_term - terminal value to compare against
//   o_hit  - high while the count equals i_term
module muldiv_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [Width-1:0] i_term,
  output logic             o_hit
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (r_cnt == i_term);

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencing controller for the EX stage.
// Launches the external multiplier or divider, stalls the pipeline while the
// unit works, and writes the {hi,lo} result for exactly one DONE cycle.
// Optional feature macro: MULDIV_DIV0_FAST_EN -- division by zero bypasses
// the divider and completes after one DIV cycle with {src_a, 32'hFFFF_FFFF}.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   flush                - kills the in-flight operation
//   op_valid, op_code    - EX holds a mult/div; 0=MULT 1=MULTU 2=DIV 3=DIVU
//   src_a, src_b         - operands, stable while stall_req=1
//   *_start              - unit enables (at most one high)
//   mul_res, mulu_res    - {hi,lo} products
//   div_ok/divu_ok, div_res/divu_res - divider done and {quotient,remainder}
//   stall_req            - pipeline stall request
//   hilo_wen, hilo_wdata - {hi,lo} write enables and data
//   busy, div_err        - FSM not idle, divider timeout pulse
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT     = MulLatDefault,
  parameter int unsigned DIV_TIMEOUT = DivTimeoutDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        mul_start,
  output logic        mulu_start,
  output logic        div_start,
  output logic        divu_start,
  input  logic [63:0] mul_res,
  input  logic [63:0] mulu_res,
  input  logic        div_ok,
  input  logic        divu_ok,
  input  logic [63:0] div_res,
  input  logic [63:0] divu_res,
  output logic        stall_req,
  output logic [1:0]  hilo_wen,
  output logic [63:0] hilo_wdata,
  output logic        busy,
  output logic        div_err
);

  localparam int unsigned MaxCnt = (MUL_LAT > DIV_TIMEOUT) ? MUL_LAT : DIV_TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  state_t      r_state;
  state_t      w_state_d;
  op_t         r_op;
  op_t         w_op_in;
  logic [63:0] r_res;
  logic        r_err;
  logic        w_req;
  logic        w_div0;
  logic        w_ok;
  logic        w_cnt_hit;
  logic [CntW-1:0] w_term;

  assign w_op_in = op_t'(op_code);
  assign w_req   = op_valid && !flush;
  assign w_ok    = (r_op == OpDivu) ? divu_ok : div_ok;

`ifdef MULDIV_DIV0_FAST_EN
  // Operands are held while stalled, so src_b is valid in both launch and DIV.
  assign w_div0 = (src_b == 32'd0);
`else
  assign w_div0 = 1'b0;
`endif

  assign w_term = (r_state == StDiv) ? CntW'(DIV_TIMEOUT - 1) : CntW'(MUL_LAT - 1);

  // Cleared throughout IDLE so every launch starts counting from zero.
  muldiv_cnt #(
    .Width (CntW)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state == StIdle),
    .i_en   ((r_state == StMul) || (r_state == StDiv)),
    .i_term (w_term),
    .o_hit  (w_cnt_hit)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_req) w_state_d = op_code[1] ? StDiv : StMul;
      StMul:  if (w_cnt_hit) w_state_d = StDone;
      StDiv:  if (w_div0 || w_ok || w_cnt_hit) w_state_d = StDone;
      // Always back to IDLE: the instruction has left EX once DONE releases the stall.
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (flush) w_state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_op    <= OpMult;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && w_req) r_op <= w_op_in;
      if (!flush) begin
        if (r_state == StMul && w_cnt_hit) begin
          r_res <= (r_op == OpMultu) ? mulu_res : mul_res;
          r_err <= 1'b0;
        end else if (r_state == StDiv) begin
          if (w_div0) begin
            r_res <= {src_a, 32'hFFFF_FFFF};
            r_err <= 1'b0;
          end else if (w_ok) begin
            // Divider returns {quotient, remainder}; HI takes the remainder.
            r_res <= (r_op == OpDivu) ? {divu_res[31:0], divu_res[63:32]}
                                      : {div_res[31:0], div_res[63:32]};
            r_err <= 1'b0;
          end else if (w_cnt_hit) begin
            r_res <= '0;
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    mul_start  = 1'b0;
    mulu_start = 1'b0;
    div_start  = 1'b0;
    divu_start = 1'b0;
    stall_req  = 1'b0;
    hilo_wen   = 2'b00;
    hilo_wdata = '0;
    div_err    = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      busy = (r_state != StIdle);
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            stall_req = 1'b1;
            unique case (w_op_in)
              OpMult:  mul_start  = 1'b1;
              OpMultu: mulu_start = 1'b1;
              OpDiv:   div_start  = !w_div0;
              OpDivu:  divu_start = !w_div0;
              default: ;
            endcase
          end
        end
        StMul: begin
          if (!flush) begin
            stall_req  = 1'b1;
            mul_start  = (r_op != OpMultu);
            mulu_start = (r_op == OpMultu);
          end
        end
        StDiv: begin
          if (!flush) begin
            stall_req  = 1'b1;
            div_start  = !w_div0 && (r_op != OpDivu);
            divu_start = !w_div0 && (r_op == OpDivu);
          end
        end
        StDone: begin
          hilo_wdata = r_res;
          if (!flush) begin
            hilo_wen = r_err ? 2'b00 : 2'b11;
            div_err  = r_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with behavioural multiplier/divider
// models and a cycle-level expectation derived from the operation rules.
module tb_muldiv_ctrl;

  localparam int MulLat = 6;
  localparam int DivTo  = 40;
`ifdef MULDIV_DIV0_FAST_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, op_valid;
  logic [1:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        mul_start, mulu_start, div_start, divu_start;
  logic [63:0] mul_res, mulu_res, div_res, divu_res;
  logic        div_ok, divu_ok;
  logic        stall_req, busy, div_err;
  logic [1:0]  hilo_wen;
  logic [63:0] hilo_wdata;

  int n_chk = 0;
  int n_err = 0;
  int mul_k = 0, mulu_k = 0, div_k = 0, divu_k = 0;
  int ok_lat = 0;

  muldiv_ctrl #(
    .MUL_LAT     (MulLat),
    .DIV_TIMEOUT (DivTo)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .src_a      (src_a),
    .src_b      (src_b),
    .mul_start  (mul_start),
    .mulu_start (mulu_start),
    .div_start  (div_start),
    .divu_start (divu_start),
    .mul_res    (mul_res),
    .mulu_res   (mulu_res),
    .div_ok     (div_ok),
    .divu_ok    (divu_ok),
    .div_res    (div_res),
    .divu_res   (divu_res),
    .stall_req  (stall_req),
    .hilo_wen   (hilo_wen),
    .hilo_wdata (hilo_wdata),
    .busy       (busy),
    .div_err    (div_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b,
                                        input bit sgn);
    longint sa, sb, p;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    p = sa * sb;
    return 64'(p);
  endfunction

  // Returns {quotient, remainder}; divide by zero yields all-ones quotient.
  function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b,
                                        input bit sgn);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = 64'(q);
    rv = 64'(r);
    return {qv[31:0], rv[31:0]};
  endfunction

  // Unit models: count cycles of continuous start; results valid after latency.
  always @(posedge clk) begin
    mul_k  <= mul_start  ? mul_k + 1  : 0;
    mulu_k <= mulu_start ? mulu_k + 1 : 0;
    div_k  <= div_start  ? div_k + 1  : 0;
    divu_k <= divu_start ? divu_k + 1 : 0;
  end

  always_comb begin
    mul_res  = (mul_k  >= MulLat) ? f_mul(src_a, src_b, 1'b1) : 64'hBADB_ADBA_DBAD_BADB;
    mulu_res = (mulu_k >= MulLat) ? f_mul(src_a, src_b, 1'b0) : 64'hBADB_ADBA_DBAD_BADB;
    div_ok   = (ok_lat > 0) && (div_k  >= ok_lat);
    divu_ok  = (ok_lat > 0) && (divu_k >= ok_lat);
    div_res  = div_ok  ? f_div(src_a, src_b, 1'b1) : 64'hDEAD_BEEF_DEAD_BEEF;
    divu_res = divu_ok ? f_div(src_a, src_b, 1'b0) : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] starts();
    return {mul_start, mulu_start, div_start, divu_start};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, ".stall"}, 64'(stall_req), 64'd0);
    chk({tag, ".start"}, 64'(starts()), 64'd0);
    chk({tag, ".wen"},   64'(hilo_wen), 64'd0);
    chk({tag, ".wdata"}, hilo_wdata, 64'd0);
    chk({tag, ".err"},   64'(div_err), 64'd0);
    chk({tag, ".busy"},  64'(busy), 64'd0);
  endtask

  // Drive one operation from an IDLE cycle (called just after a negedge) and
  // check every cycle through DONE. Returns at the next negedge, op_valid still 1.
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                       input int ok_after, input bit flush_done, input string tag);
    int          n_stall;
    bit          exp_err;
    logic [63:0] exp_data, dr;
    logic [3:0]  exp_st;
    exp_err = 1'b0;
    if (op < 2) begin
      n_stall  = MulLat + 1;
      exp_data = f_mul(a, b, op == 0);
      exp_st   = (op == 0) ? 4'b1000 : 4'b0100;
    end else if (Fast && b == 32'd0) begin
      n_stall  = 2;
      exp_data = {a, 32'hFFFF_FFFF};
      exp_st   = 4'b0000;
    end else begin
      dr       = f_div(a, b, op == 2);
      exp_data = {dr[31:0], dr[63:32]};
      exp_st   = (op == 2) ? 4'b0010 : 4'b0001;
      if (ok_after <= DivTo) begin
        n_stall = ok_after + 1;
      end else begin
        n_stall = DivTo + 1;
        exp_err = 1'b1;
      end
    end
    ok_lat   = ok_after;
    op_valid = 1'b1;
    op_code  = 2'(op);
    src_a    = a;
    src_b    = b;
    for (int i = 0; i < n_stall; i++) begin
      #1;
      chk($sformatf("%s.stall@%0d", tag, i), 64'(stall_req), 64'd1);
      chk($sformatf("%s.busy@%0d", tag, i),  64'(busy), 64'(i != 0));
      chk($sformatf("%s.start@%0d", tag, i), 64'(starts()), 64'(exp_st));
      chk($sformatf("%s.wen@%0d", tag, i),   64'(hilo_wen), 64'd0);
      chk($sformatf("%s.wdata@%0d", tag, i), hilo_wdata, 64'd0);
      chk($sformatf("%s.err@%0d", tag, i),   64'(div_err), 64'd0);
      @(negedge clk);
    end
    flush = flush_done;
    #1;
    chk({tag, ".done.stall"}, 64'(stall_req), 64'd0);
    chk({tag, ".done.busy"},  64'(busy), 64'd1);
    chk({tag, ".done.start"}, 64'(starts()), 64'd0);
    chk({tag, ".done.wen"},   64'(hilo_wen), (exp_err || flush_done) ? 64'd0 : 64'd3);
    chk({tag, ".done.err"},   64'(div_err), 64'(exp_err && !flush_done));
    if (!exp_err && !flush_done) chk({tag, ".done.wdata"}, hilo_wdata, exp_data);
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    op_valid = 1'b0;
    #1;
    chk_quiet(tag);
    @(negedge clk);
  endtask

  initial begin
    int          op, oka;
    logic [31:0] ra, rb;
    rst = 1'b1; flush = 1'b0; op_valid = 1'b1; op_code = 2'd0;
    src_a = 32'd1; src_b = 32'd2;

    // Reset holds every output low even with a pending request.
    repeat (3) begin
      @(negedge clk);
      #1;
      chk_quiet("reset");
    end
    @(negedge clk);
    rst = 1'b0; op_valid = 1'b0;
    idle_cycle("idle0");

    // MULT -2 x 3
    do_op(0, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, "mult");
    idle_cycle("mult.post");

    // DIVU 100/7, ok after 33 cycles
    do_op(3, 32'd100, 32'd7, 33, 1'b0, "divu");
    idle_cycle("divu.post");

    // DIV with ok never asserted -> timeout
    do_op(2, 32'd1000, 32'd3, 1000, 1'b0, "divto");
    idle_cycle("divto.post");

    // Flush in the third MUL cycle
    op_valid = 1'b1; op_code = 2'd0; src_a = 32'd7; src_b = 32'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("fl.start@%0d", i), 64'(starts()), 64'b1000);
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    chk("fl.stall", 64'(stall_req), 64'd0);
    chk("fl.start", 64'(starts()), 64'd0);
    chk("fl.wen", 64'(hilo_wen), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    repeat (MulLat + 2) idle_cycle("fl.after");
    do_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "multu");
    idle_cycle("multu.post");

    // Flush while a request is presented in IDLE
    op_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flidle.stall", 64'(stall_req), 64'd0);
    chk("flidle.start", 64'(starts()), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    idle_cycle("flidle.after");

    // Back-to-back MULTs; the second launch happens from IDLE (busy=0 at its cycle 0)
    do_op(0, 32'd12345, 32'hFFFF_FF00, 0, 1'b0, "b2b1");
    do_op(0, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, "b2b2");
    idle_cycle("b2b.post");

    // Flush during DONE suppresses the write
    do_op(1, 32'd5, 32'd6, 0, 1'b1, "fldone");
    idle_cycle("fldone.post");

    // Reset in the middle of a DIVU
    op_valid = 1'b1; op_code = 2'd3; src_a = 32'd50; src_b = 32'd5; ok_lat = 1000;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("rstmid.a");
    @(negedge clk);
    #1;
    chk_quiet("rstmid.b");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) idle_cycle("rstmid.after");

    // DIV 5/0
    do_op(2, 32'd5, 32'd0, 3, 1'b0, "div0");
    idle_cycle("div0.post");

    // Randomised operations
    for (int n = 0; n < 12; n++) begin
      op  = int'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      oka = int'($urandom_range(1, DivTo + 3));
      do_op(op, ra, rb, oka, 1'b0, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) idle_cycle($sformatf("rnd%0d.post", n));
    end
    idle_cycle("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
